// File: rtl/lsu_mem_initiator_if.sv
// Shared types and bus interfaces for the load/store initiator:
// CPU-side request/response bus and the word-memory data port.
package lsu_mem_pkg;
    typedef enum logic [1:0] {
        TSIZE_BYTE = 2'd0,
        TSIZE_HALF = 2'd1,
        TSIZE_WORD = 2'd2
    } tsize_e;
endpackage

interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

interface lsu_mem_if #(
    parameter int unsigned ADDR_W = 10
);
    logic [ADDR_W-1:0]    mem_address;
    lsu_mem_pkg::tsize_e  mem_tsize;
    logic                 mem_write;
    logic [31:0]          mem_write_data;
    logic [31:0]          mem_data;
    logic                 mem_rerror;
    logic                 mem_werror;

    modport master (
        output mem_address, mem_tsize, mem_write, mem_write_data,
        input  mem_data, mem_rerror, mem_werror
    );

    modport slave (
        input  mem_address, mem_tsize, mem_write, mem_write_data,
        output mem_data, mem_rerror, mem_werror
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator for a registered-address word memory: one request at a
// time, pre-checked, sub-word stores done as read-modify-write.
module lsu_mem_initiator
    import lsu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    lsu_req_if.slave       lsu,
    lsu_mem_if.master      mem
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LD_DATA   = 3'd1,
        S_ST_WRITE  = 3'd2,
        S_RMW_READ  = 3'd3,
        S_RMW_WRITE = 3'd4,
        S_RESP      = 3'd5
    } state_e;

    state_e            r_state;
    logic [2:0]        r_funct3;
    logic [1:0]        r_byte_off;
    logic [15:0]       r_wdata;
    logic [ADDR_W-1:0] r_mem_addr;
    tsize_e            r_tsize;
    logic              r_mem_write;
    logic [XLEN-1:0]   r_mem_write_data;
    logic              r_resp_valid;
    logic [XLEN-1:0]   r_resp_rdata;
    logic              r_resp_error;

    logic              w_idle;
    logic              w_accept;
    logic              w_f3_legal;
    logic              w_out_of_range;
    logic              w_misaligned;
    logic              w_pre_err;
    logic              w_sub_word_store;
    logic [ADDR_W-1:0] w_req_mem_addr;
    tsize_e            w_load_tsize;
    logic [XLEN-1:0]   w_load_data;
    logic [XLEN-1:0]   w_merged;

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = lsu.req_valid && w_idle;

    // Request pre-check: legal width code, in-range address, natural alignment.
    always_comb begin
        w_f3_legal = 1'b0;
        case (lsu.req_funct3)
            3'b000, 3'b001, 3'b010: w_f3_legal = 1'b1;
            3'b100, 3'b101:         w_f3_legal = !lsu.req_write;
            default:                w_f3_legal = 1'b0;
        endcase
    end

    assign w_out_of_range = |lsu.req_addr[XLEN-1:ADDR_W];
    assign w_misaligned   = ((lsu.req_funct3[1:0] == 2'b01) && lsu.req_addr[0]) ||
                            ((lsu.req_funct3[1:0] == 2'b10) && (lsu.req_addr[1:0] != 2'b00));
    assign w_pre_err      = !w_f3_legal || w_out_of_range || w_misaligned;

    // Sub-word stores read the whole containing word first.
    assign w_sub_word_store = lsu.req_write && (lsu.req_funct3[1:0] != 2'b10);
    assign w_req_mem_addr   = w_sub_word_store ? {lsu.req_addr[ADDR_W-1:2], 2'b00}
                                               : lsu.req_addr[ADDR_W-1:0];

    always_comb begin
        case (lsu.req_funct3[1:0])
            2'b00:   w_load_tsize = TSIZE_BYTE;
            2'b01:   w_load_tsize = TSIZE_HALF;
            default: w_load_tsize = TSIZE_WORD;
        endcase
    end

    // Memory returns lane-shifted, zero-extended data; only signed loads need work.
    always_comb begin
        case (r_funct3)
            3'b000:  w_load_data = {{24{mem.mem_data[7]}},  mem.mem_data[7:0]};
            3'b001:  w_load_data = {{16{mem.mem_data[15]}}, mem.mem_data[15:0]};
            3'b100:  w_load_data = {24'd0, mem.mem_data[7:0]};
            3'b101:  w_load_data = {16'd0, mem.mem_data[15:0]};
            default: w_load_data = mem.mem_data;
        endcase
    end

    always_comb begin
        w_merged = mem.mem_data;
        if (r_funct3[1:0] == 2'b00) begin
            w_merged[{r_byte_off, 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merged[{r_byte_off[1], 4'b0000} +: 16] = r_wdata[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_funct3         <= 3'd0;
            r_byte_off       <= 2'd0;
            r_wdata          <= 16'd0;
            r_mem_addr       <= '0;
            r_tsize          <= TSIZE_WORD;
            r_mem_write      <= 1'b0;
            r_mem_write_data <= '0;
            r_resp_valid     <= 1'b0;
            r_resp_rdata     <= '0;
            r_resp_error     <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_mem_write  <= 1'b0;
            r_tsize      <= TSIZE_WORD;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_funct3   <= lsu.req_funct3;
                        r_byte_off <= lsu.req_addr[1:0];
                        r_wdata    <= lsu.req_wdata[15:0];
                        r_mem_addr <= w_req_mem_addr;
                        if (w_pre_err) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= '0;
                            r_resp_error <= 1'b1;
                        end else if (!lsu.req_write) begin
                            r_state <= S_LD_DATA;
                            r_tsize <= w_load_tsize;
                        end else if (lsu.req_funct3[1:0] == 2'b10) begin
                            r_state          <= S_ST_WRITE;
                            r_mem_write      <= 1'b1;
                            r_mem_write_data <= lsu.req_wdata;
                        end else begin
                            r_state <= S_RMW_READ;
                        end
                    end
                end
                S_LD_DATA: begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= mem.mem_rerror ? '0 : w_load_data;
                    r_resp_error <= mem.mem_rerror;
                end
                S_ST_WRITE, S_RMW_WRITE: begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= '0;
                    r_resp_error <= mem.mem_werror;
                end
                S_RMW_READ: begin
                    // A failed read must not be followed by a write of a corrupt word.
                    if (mem.mem_rerror) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= '0;
                        r_resp_error <= 1'b1;
                    end else begin
                        r_state          <= S_RMW_WRITE;
                        r_mem_write      <= 1'b1;
                        r_mem_write_data <= w_merged;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign lsu.req_ready      = w_idle;
    assign lsu.resp_valid     = r_resp_valid;
    assign lsu.resp_rdata     = r_resp_rdata;
    assign lsu.resp_error     = r_resp_error;

    // In IDLE the address goes straight through so the memory registers it on accept.
    assign mem.mem_address    = w_idle ? w_req_mem_addr : r_mem_addr;
    assign mem.mem_tsize      = r_tsize;
    assign mem.mem_write      = r_mem_write;
    assign mem.mem_write_data = r_mem_write_data;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a registered-address word memory
// model and a response scoreboard (data, error flag, latency).
module tb_lsu_mem_initiator;
    import lsu_mem_pkg::*;

    localparam int unsigned ADDR_W = 10;

    logic clk;
    logic rst_n;

    lsu_req_if                     lsu_bus ();
    lsu_mem_if #(.ADDR_W(ADDR_W))  mem_bus ();

    lsu_mem_initiator #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lsu   (lsu_bus.slave),
        .mem   (mem_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        string       tag;
    } exp_t;

    exp_t exp_q [$];
    int   stamp_q [$];
    int   acc_log [$];
    int   pcount;
    int   checks;
    int   failures;

    // Memory model: address registered every edge, whole-word writes.
    logic [31:0] mem_arr [0:255];
    logic [9:0]  r_maddr;
    logic        pl_en;
    logic [9:0]  pl_addr;
    logic [31:0] pl_data;
    logic        tb_rerr;
    int          wr_count;
    logic [31:0] last_wd;
    logic [31:0] rd_word;

    always @(posedge clk) begin
        if (pl_en) mem_arr[pl_addr[9:2]] <= pl_data;
        else if (mem_bus.mem_write) mem_arr[r_maddr[9:2]] <= mem_bus.mem_write_data;
        if (mem_bus.mem_write) begin
            wr_count <= wr_count + 1;
            last_wd  <= mem_bus.mem_write_data;
        end
        r_maddr <= mem_bus.mem_address;
    end

    always_comb begin
        rd_word = mem_arr[r_maddr[9:2]];
        case (mem_bus.mem_tsize)
            TSIZE_BYTE: mem_bus.mem_data = (rd_word >> {r_maddr[1:0], 3'b000}) & 32'h0000_00FF;
            TSIZE_HALF: mem_bus.mem_data = (rd_word >> {r_maddr[1], 4'b0000}) & 32'h0000_FFFF;
            default:    mem_bus.mem_data = rd_word;
        endcase
    end

    assign mem_bus.mem_rerror = tb_rerr;
    assign mem_bus.mem_werror = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept timestamps.
    always @(posedge clk) begin
        pcount <= pcount + 1;
        if (rst_n && lsu_bus.req_valid && lsu_bus.req_ready) begin
            stamp_q.push_back(pcount);
            acc_log.push_back(pcount);
        end
    end

    // Response scoreboard.
    always @(negedge clk) begin
        if (rst_n && lsu_bus.resp_valid) begin
            if (exp_q.size() == 0 || stamp_q.size() == 0) begin
                chk("resp_without_request", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_t e;
                int   s;
                e = exp_q.pop_front();
                s = stamp_q.pop_front();
                chk({e.tag, "_rdata"}, lsu_bus.resp_rdata, e.rdata);
                chk({e.tag, "_error"}, 32'(lsu_bus.resp_error), 32'(e.err));
                chk({e.tag, "_latency"}, 32'(pcount - s), 32'(e.lat));
            end
        end
    end

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee,
                         input int el, input string tag);
        exp_t e;
        int   n;
        @(negedge clk);
        lsu_bus.req_valid  = 1'b1;
        lsu_bus.req_write  = w;
        lsu_bus.req_funct3 = f3;
        lsu_bus.req_addr   = a;
        lsu_bus.req_wdata  = wd;
        e.rdata = er; e.err = ee; e.lat = el; e.tag = tag;
        exp_q.push_back(e);
        n = 0;
        while (!lsu_bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk({tag, "_accept_timeout"}, 32'(lsu_bus.req_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic drain(input string tag);
        int n;
        @(negedge clk);
        lsu_bus.req_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    int wc0;
    int ai;

    initial begin
        checks = 0; failures = 0; pcount = 0; wr_count = 0; last_wd = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0; tb_rerr = 1'b0;
        lsu_bus.req_valid = 1'b0; lsu_bus.req_write = 1'b0;
        lsu_bus.req_funct3 = 3'd0; lsu_bus.req_addr = '0; lsu_bus.req_wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_resp_valid", 32'(lsu_bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", lsu_bus.resp_rdata, 32'd0);
        chk("rst_resp_error", 32'(lsu_bus.resp_error), 32'd0);
        chk("rst_mem_write", 32'(mem_bus.mem_write), 32'd0);
        chk("rst_mem_wdata", mem_bus.mem_write_data, 32'd0);
        chk("rst_req_ready", 32'(lsu_bus.req_ready), 32'd1);
        chk("rst_tsize", 32'(mem_bus.mem_tsize), 32'(TSIZE_WORD));

        // Loads and extension.
        preload(10'h010, 32'h8899_AABB);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h8899_AABB, 1'b0, 2, "lw_10");
        drain("lw_10");
        preload(10'h010, 32'h8011_2233);
        issue(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FF80, 1'b0, 2, "lb_13");
        issue(1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_0080, 1'b0, 2, "lbu_13");
        issue(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_8011, 1'b0, 2, "lh_12");
        issue(1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_8011, 1'b0, 2, "lhu_12");
        issue(1'b0, 3'b000, 32'h10, 32'h0, 32'h0000_0033, 1'b0, 2, "lb_10");
        drain("loads");

        // Sub-word stores via read-modify-write.
        preload(10'h020, 32'h1122_3344);
        wc0 = wr_count;
        issue(1'b1, 3'b000, 32'h21, 32'hFFFF_FFCD, 32'h0, 1'b0, 3, "sb_21");
        drain("sb_21");
        chk("sb_21_write_count", 32'(wr_count - wc0), 32'd1);
        chk("sb_21_write_data", last_wd, 32'h1122_CD44);
        wc0 = wr_count;
        issue(1'b1, 3'b001, 32'h22, 32'h1234_BEEF, 32'h0, 1'b0, 3, "sh_22");
        drain("sh_22");
        chk("sh_22_write_count", 32'(wr_count - wc0), 32'd1);
        issue(1'b0, 3'b010, 32'h20, 32'h0, 32'hBEEF_CD44, 1'b0, 2, "lw_20");
        drain("lw_20");

        // Pre-check errors: no memory write, response one cycle after accept.
        wc0 = wr_count;
        issue(1'b1, 3'b010, 32'h22, 32'h5555_5555, 32'h0, 1'b1, 1, "sw_misalign");
        issue(1'b0, 3'b001, 32'h05, 32'h0, 32'h0, 1'b1, 1, "lh_misalign");
        issue(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1, 1, "lw_range");
        issue(1'b1, 3'b100, 32'h20, 32'h0, 32'h0, 1'b1, 1, "st_f3_100");
        issue(1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1, 1, "ld_f3_011");
        drain("errors");
        chk("errors_write_count", 32'(wr_count - wc0), 32'd0);

        // Memory read errors.
        tb_rerr = 1'b1;
        wc0 = wr_count;
        issue(1'b1, 3'b000, 32'h20, 32'hAA, 32'h0, 1'b1, 2, "sb_rerr");
        issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 1'b1, 2, "lw_rerr");
        drain("rerr");
        tb_rerr = 1'b0;
        chk("rerr_write_count", 32'(wr_count - wc0), 32'd0);

        // Reset during RMW_READ of a halfword store.
        preload(10'h040, 32'h0102_0304);
        wc0 = wr_count;
        @(negedge clk);
        lsu_bus.req_valid = 1'b1; lsu_bus.req_write = 1'b1;
        lsu_bus.req_funct3 = 3'b001; lsu_bus.req_addr = 32'h42; lsu_bus.req_wdata = 32'hFACE;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        lsu_bus.req_valid = 1'b0;
        #1;
        chk("abort_mem_write", 32'(mem_bus.mem_write), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_write_in_reset", 32'(mem_bus.mem_write), 32'd0);
        end
        rst_n = 1'b1;
        stamp_q.delete();
        @(negedge clk);
        chk("abort_req_ready", 32'(lsu_bus.req_ready), 32'd1);
        chk("abort_write_count", 32'(wr_count - wc0), 32'd0);
        issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h0102_0304, 1'b0, 2, "lw_after_abort");
        drain("lw_after_abort");

        // Back-to-back with req_valid held high.
        ai = acc_log.size();
        issue(1'b1, 3'b010, 32'h30, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, "sw_30");
        issue(1'b0, 3'b010, 32'h30, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, "lw_30");
        drain("b2b");
        if (acc_log.size() >= ai + 2) begin
            chk("b2b_accept_gap", 32'(acc_log[ai+1] - acc_log[ai]), 32'd3);
        end else begin
            chk("b2b_accept_count", 32'(acc_log.size() - ai), 32'd2);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_mem_initiator.md
# lsu_mem_initiator

Load/store initiator that drives the data port of the single-cycle-registered-address word memory on behalf of the CPU core. Accepts one load or store request at a time, checks alignment and range, and sequences the memory's one-cycle-delayed address pipeline. Byte/halfword stores are done as read-modify-write because the memory writes whole words only. Sign-extends load results and returns a single-cycle response with an error flag.

## Interface
- ADDR_W, 10, memory byte-address width (memory depth N = 2**ADDR_W bytes)
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block idle, request accepted on `req_valid && req_ready`
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle response pulse, no backpressure
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_error  out  1  misaligned, out of range, illegal funct3, or memory error
- mem_address  out  ADDR_W  memory address, registered inside the memory
- mem_tsize  out  tsize_e  BYTE/HALFWORD/WORD, qualifies the read cycle
- mem_write  out  1  write strobe, uses the memory's registered address
- mem_write_data  out  32  full-word write data
- mem_data  in  32  read data for the registered address, lane-shifted, zero-extended
- mem_rerror  in  1  memory read error
- mem_werror  in  1  memory write error

## Operation
- States: IDLE, LD_DATA, ST_WRITE, RMW_READ, RMW_WRITE, RESP.
- IDLE: req_ready=1. mem_address is driven combinationally from req_addr: `req_addr[ADDR_W-1:0]` for loads and word stores, `{req_addr[ADDR_W-1:2],2'b00}` for SB/SH. Outside IDLE, mem_address is the latched value.
- On accept, latch write, funct3, addr, and wdata.
- Pre-check on accept. An error is flagged when any of these holds: funct3 is illegal (for stores, only 000/001/010 are legal); `req_addr[31:ADDR_W]` is nonzero; a halfword access has addr[0]=1; a word access has addr[1:0]≠0. On error go to RESP with error=1 and issue no memory write.
- Load goes to LD_DATA. mem_tsize = width of the op. Capture `mem_data` and `mem_rerror` this cycle.
  - LB sign-extends bit 7; LH sign-extends bit 15; LW, LBU, and LHU pass through.
  - Then go to RESP.
- SW goes to ST_WRITE: mem_write=1, mem_write_data=wdata, sample mem_werror, then go to RESP.
- SB/SH goes to RMW_READ with mem_tsize=WORD. Capture mem_data and merge the new lane:
  - SB replaces byte addr[1:0] with `wdata[7:0]`.
  - SH replaces halfword addr[1] with `wdata[15:0]`.
  - A mem_rerror here aborts to RESP with error=1 and no write.
  - Otherwise go to RMW_WRITE: mem_write=1, mem_write_data=merged word, then go to RESP.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0, then go to IDLE.
- mem_tsize = WORD in all states except LD_DATA.
- mem_write is asserted only in ST_WRITE and RMW_WRITE.

## Timing
- Reset (async): state=IDLE. resp_valid=0, resp_rdata=0, resp_error=0, mem_write=0, mem_write_data=0. req_ready=1 after reset release.
- Reset mid-operation aborts immediately, with no write issued after rst_n falls.
- Accept at edge E0. The memory registers the address at E0.
- Latency, counted as the cycle in which resp_valid is high:
  - Load and SW: cycle E0+2.
  - SB/SH: cycle E0+3.
  - Pre-check error: cycle E0+1.
- resp_rdata and resp_error are registered and valid only while resp_valid=1. They hold until the next response.
- Back-to-back: the earliest next accept is in the cycle after RESP. Requests with req_valid high during busy states are not accepted and must be held.
- The memory is single-port. No access overlaps another.

## Test plan
- LW at 0x10 with mem word 0x8899AABB → resp_valid at E0+2, rdata=0x8899AABB, error=0.
- LB at 0x13 with mem word 0x80112233 → rdata=0xFFFFFF80. LBU at the same address → 0x00000080. LH at 0x12 → 0xFFFF8011.
- SB at 0x21 with wdata 0xCD and old word 0x11223344 → RMW_READ then RMW_WRITE. mem_write_data=0x1122CD44, a single mem_write pulse, resp at E0+3.
- SW at 0x22 → resp_error=1 at E0+1, mem_write never asserted. LH at 0x05 and LW at 0x400 (with ADDR_W=10) → error=1 likewise.
- Assert rst_n low during RMW_READ of an SH → mem_write stays 0, no resp_valid, next request accepted normally.
- Back-to-back SW 0x30 = 0xDEADBEEF, then LW 0x30 with req_valid held high → second accept in the cycle after the first RESP, rdata=0xDEADBEEF.
